// File: rtl/imem_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_unit
// Description : Clocked, writable instruction memory behind a request/valid
//               fetch handshake with WAIT_STATES extra cycles of latency.
//               Misaligned or out-of-range fetches return a NOP word with
//               o_fault set. A separate program port writes words at any time.
//               Optional macro IMEM_FETCH_FLUSH_EN adds i_flush, which cancels
//               a pending fetch and masks o_ready.
// Ports       : i_clk, i_clrn (async active-low reset)
//               i_req / i_addr      fetch request and byte address
//               o_ready             request can be accepted this cycle
//               o_valid / o_inst / o_fault  one-cycle response
//               i_wr_en / i_wr_addr / i_wr_data  program write port
//               i_flush             (IMEM_FETCH_FLUSH_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_unit #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic                  i_clk,
    input  logic                  i_clrn,
`ifdef IMEM_FETCH_FLUSH_EN
    input  logic                  i_flush,
`endif
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  o_ready,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_inst,
    output logic                  o_fault,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [DATA_W-1:0]     i_wr_data
);

    localparam int         C_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [3:0]            r_cnt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_inst;
    logic                  r_fault;
    logic [DATA_W-1:0]     r_mem [C_DEPTH];

    logic                  w_flush;
    logic                  w_accept;
    logic                  w_wait_done;
    logic                  w_load;
    logic [ADDR_W-1:0]     w_load_addr;
    logic                  w_bad;
    logic [DEPTH_LOG2-1:0] w_idx;

`ifdef IMEM_FETCH_FLUSH_EN
    assign w_flush = i_flush;
`else
    assign w_flush = 1'b0;
`endif

    assign o_ready     = (r_state != S_WAIT) && !w_flush;
    assign o_valid     = (r_state == S_RESP);
    assign o_inst      = r_inst;
    assign o_fault     = r_fault;
    assign w_accept    = i_req && o_ready;
    assign w_wait_done = (r_state == S_WAIT) && (r_cnt == 4'd1) && !w_flush;

    // With zero wait states the response is loaded on the accepting edge
    // itself, so the word is looked up from the live address instead of the
    // latched one.
    assign w_load      = w_wait_done || ((WAIT_STATES == 0) && w_accept);
    assign w_load_addr = (WAIT_STATES == 0) ? i_addr : r_addr;
    assign w_bad       = (w_load_addr[1:0] != 2'b00) ||
                         (w_load_addr[ADDR_W-1:DEPTH_LOG2+2] != '0);
    assign w_idx       = w_load_addr[DEPTH_LOG2+1:2];

    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (r_cnt == 4'd1) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (w_accept) begin
                    w_state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_clrn) begin
        if (!i_clrn) begin
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_inst  <= '0;
            r_fault <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr <= i_addr;
                r_cnt  <= C_WAIT_INIT;
            end else if ((r_state == S_WAIT) && w_flush) begin
                r_cnt <= 4'd0;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            // Non-blocking read of r_mem sees the pre-write contents when the
            // program port hits the same word on this edge.
            if (w_load) begin
                r_inst  <= w_bad ? '0 : r_mem[w_idx];
                r_fault <= w_bad;
            end
        end
    end

    // Array contents are deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_unit.sv
`default_nettype none
module tb_imem_fetch_unit;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DL = 8;
    localparam int ND = 3;   // instance 0: WS=0, 1: WS=1, 2: WS=3

    logic          clk = 1'b0;
    logic          clrn;
    logic          req   [ND];
    logic [AW-1:0] addr  [ND];
    logic          ready [ND];
    logic          valid [ND];
    logic          fault [ND];
    logic [DW-1:0] inst  [ND];
    logic          wr_en;
    logic [DL-1:0] wr_addr;
    logic [DW-1:0] wr_data;
`ifdef IMEM_FETCH_FLUSH_EN
    logic          flush [ND];
`endif

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem_m [256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        imem_fetch_unit #(
            .ADDR_W      (AW),
            .DATA_W      (DW),
            .DEPTH_LOG2  (DL),
            .WAIT_STATES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
        ) u_dut (
            .i_clk     (clk),
            .i_clrn    (clrn),
`ifdef IMEM_FETCH_FLUSH_EN
            .i_flush   (flush[g]),
`endif
            .i_req     (req[g]),
            .i_addr    (addr[g]),
            .o_ready   (ready[g]),
            .o_valid   (valid[g]),
            .o_inst    (inst[g]),
            .o_fault   (fault[g]),
            .i_wr_en   (wr_en),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data)
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 1 : 3);
    endfunction

    // 256 words of 4 bytes: any byte address that is not a multiple of 4 or
    // is at/above 1024 is a bad fetch.
    function automatic bit model_fault(input logic [31:0] a);
        return ((a % 32'd4) != 0) || (a >= 32'd1024);
    endfunction

    function automatic logic [31:0] model_inst(input logic [31:0] a);
        if (model_fault(a)) return 32'h0;
        return mem_m[int'(a / 32'd4)];
    endfunction

    function automatic logic [31:0] gen_addr();
        int sel;
        sel = int'($urandom_range(0, 7));
        if (sel <= 4) return 32'($urandom_range(0, 255)) * 32'd4;
        if (sel == 5) return 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
        if (sel == 6) return 32'd1024 + 32'($urandom_range(0, 4095));
        return $urandom | 32'h8000_0000;
    endfunction

    task automatic write_word(input int idx, input logic [31:0] data);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 8'(idx); wr_data = data;
        @(posedge clk);
        #1 wr_en = 1'b0;
        mem_m[idx] = data;
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < ND; d++) begin
            checks++;
            if (ready[d] !== 1'b1 || valid[d] !== 1'b0 || inst[d] !== 32'h0 || fault[d] !== 1'b0) begin
                errors++;
                $display("FAIL %s d=%0d got rdy=%b vld=%b inst=%h flt=%b exp rdy=1 vld=0 inst=0 flt=0",
                         tag, d, ready[d], valid[d], inst[d], fault[d]);
            end
        end
    endtask

    // One fetch; optionally toggles Req randomly while the unit is busy.
    task automatic fetch_check(input int d, input logic [31:0] a, input bit poke);
        int lat; bit seen; logic [31:0] ei; bit ef;
        @(negedge clk);
        checks++;
        if (ready[d] !== 1'b1) begin
            errors++; $display("FAIL fetch_ready d=%0d got %b exp 1", d, ready[d]);
        end
        req[d] = 1'b1; addr[d] = a;
        ei = model_inst(a); ef = model_fault(a);
        @(posedge clk);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (valid[d] === 1'b1) begin
                seen = 1'b1; req[d] = 1'b0;
            end else begin
                checks++;
                if (ready[d] !== 1'b0) begin
                    errors++; $display("FAIL ready_in_wait d=%0d got %b exp 0", d, ready[d]);
                end
                req[d] = poke ? ($urandom_range(0, 1) == 1) : 1'b0;
                addr[d] = $urandom;
            end
        end
        req[d] = 1'b0;
        checks++;
        if (!seen || lat != ws_of(d) + 1) begin
            errors++; $display("FAIL latency d=%0d addr=%h got %0d exp %0d", d, a, seen ? lat : -1, ws_of(d) + 1);
        end else begin
            checks++;
            if (inst[d] !== ei || fault[d] !== ef) begin
                errors++; $display("FAIL fetch_data d=%0d addr=%h got %h/%b exp %h/%b", d, a, inst[d], fault[d], ei, ef);
            end
        end
        @(negedge clk);
        checks++;
        if (valid[d] !== 1'b0 || ready[d] !== 1'b1) begin
            errors++; $display("FAIL valid_pulse d=%0d got vld=%b rdy=%b exp 0/1", d, valid[d], ready[d]);
        end
    endtask

    task automatic test_back_to_back(input int d, input logic [31:0] aq[$]);
        int idx, lat, guard;
        idx = 0; lat = 0; guard = 0;
        @(negedge clk);
        req[d] = 1'b1; addr[d] = aq[0];
        @(posedge clk);
        while (idx < aq.size() && guard < 40 * aq.size()) begin
            @(negedge clk);
            lat++; guard++;
            if (valid[d] === 1'b1) begin
                checks++;
                if (lat != ws_of(d) + 1 || inst[d] !== model_inst(aq[idx]) || fault[d] !== model_fault(aq[idx])) begin
                    errors++;
                    $display("FAIL b2b d=%0d addr=%h got lat=%0d %h/%b exp lat=%0d %h/%b", d, aq[idx], lat,
                             inst[d], fault[d], ws_of(d) + 1, model_inst(aq[idx]), model_fault(aq[idx]));
                end
                idx++; lat = 0;
                if (idx < aq.size()) begin
                    req[d] = 1'b1; addr[d] = aq[idx];
                end else begin
                    req[d] = 1'b0;
                end
            end else begin
                req[d] = 1'b0;
            end
        end
        req[d] = 1'b0;
        checks++;
        if (idx != aq.size()) begin
            errors++; $display("FAIL b2b_timeout d=%0d got %0d responses exp %0d", d, idx, aq.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 clrn = 1'b0;
        #1 check_reset_outputs("reset_initial");
        @(negedge clk); @(negedge clk);
        clrn = 1'b1;
        @(negedge clk);
        check_reset_outputs("reset_idle");
    endtask

    task automatic test_program();
        logic [31:0] q[$];
        write_word(0, 32'h2001_0054);
        write_word(1, 32'h2002_0033);
        q = '{32'h0, 32'h4};
        test_back_to_back(1, q);
    endtask

    task automatic test_latency();
        for (int d = 0; d < ND; d++) fetch_check(d, 32'h8, 1'b1);
    endtask

    task automatic test_faults();
        for (int d = 0; d < ND; d++) begin
            fetch_check(d, 32'h6, 1'b0);
            fetch_check(d, 32'h400, 1'b0);
            fetch_check(d, 32'h10, 1'b0);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        for (int d = 0; d < ND; d++) begin
            q.delete();
            for (int i = 0; i < 16; i++) q.push_back(gen_addr());
            test_back_to_back(d, q);
            for (int i = 0; i < 6; i++) fetch_check(d, gen_addr(), 1'b1);
        end
    endtask

    task automatic test_collision();
        write_word(5, 32'hAAAA_0000);
        @(negedge clk);
        req[1] = 1'b1; addr[1] = 32'h14;
        @(posedge clk);
        @(negedge clk);
        req[1] = 1'b0;
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'h5555_FFFF;
        @(posedge clk);
        #1 wr_en = 1'b0;
        mem_m[5] = 32'h5555_FFFF;
        @(negedge clk);
        checks++;
        if (valid[1] !== 1'b1 || inst[1] !== 32'hAAAA_0000 || fault[1] !== 1'b0) begin
            errors++; $display("FAIL collision_old d=1 got vld=%b inst=%h flt=%b exp 1/aaaa0000/0", valid[1], inst[1], fault[1]);
        end
        fetch_check(1, 32'h14, 1'b0);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        req[2] = 1'b1; addr[2] = 32'h0;
        @(posedge clk);
        #1 req[2] = 1'b0;
        #2 clrn = 1'b0;
        #1 check_reset_outputs("reset_async");
        @(negedge clk);
        clrn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (valid[2] !== 1'b0 || ready[2] !== 1'b1) begin
                errors++; $display("FAIL reset_abort d=2 got vld=%b rdy=%b exp 0/1", valid[2], ready[2]);
            end
        end
        fetch_check(2, 32'h4, 1'b0);
    endtask

`ifdef IMEM_FETCH_FLUSH_EN
    task automatic test_flush();
        @(negedge clk);
        req[2] = 1'b1; addr[2] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        req[2] = 1'b0; flush[2] = 1'b1;
        @(posedge clk);
        #1 flush[2] = 1'b0;
        #1;
        checks++;
        if (ready[2] !== 1'b1 || valid[2] !== 1'b0) begin
            errors++; $display("FAIL flush_idle d=2 got rdy=%b vld=%b exp 1/0", ready[2], valid[2]);
        end
        @(negedge clk);
        flush[2] = 1'b1; req[2] = 1'b1; addr[2] = 32'h4;
        #1;
        checks++;
        if (ready[2] !== 1'b0) begin
            errors++; $display("FAIL flush_mask d=2 got rdy=%b exp 0", ready[2]);
        end
        @(posedge clk);
        #1 flush[2] = 1'b0; req[2] = 1'b0;
        #1;
        checks++;
        if (ready[2] !== 1'b1) begin
            errors++; $display("FAIL flush_drop d=2 got rdy=%b exp 1", ready[2]);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (valid[2] !== 1'b0) begin
                errors++; $display("FAIL flush_novalid d=2 got vld=%b exp 0", valid[2]);
            end
        end
        fetch_check(2, 32'h8, 1'b0);
    endtask
`endif

    initial begin
        clrn = 1'b1;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        for (int d = 0; d < ND; d++) begin
            req[d] = 1'b0; addr[d] = '0;
`ifdef IMEM_FETCH_FLUSH_EN
            flush[d] = 1'b0;
`endif
        end
        test_reset();
        test_program();
        for (int i = 2; i < 256; i++) write_word(i, $urandom);
        test_latency();
        test_faults();
        test_random();
        test_collision();
        test_mid_reset();
`ifdef IMEM_FETCH_FLUSH_EN
        test_flush();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imem_fetch_unit.md
Name: imem_fetch_unit

Overview:
- Parametrised, clocked instruction memory for the single-cycle and multi-cycle CPU datapaths.
- Replaces a combinational ROM with a writable word array behind a request/valid fetch handshake with configurable wait states.
- Adds a programming write port so testbenches and boot logic can load programs at run time.
- Flags misaligned and out-of-range fetches.

Parameters:
- ADDR_W, 32: width of the byte fetch address.
- DATA_W, 32: instruction word width.
- DEPTH_LOG2, 8: log2 of the number of words (default 256 words).
- WAIT_STATES, 1: extra cycles between request acceptance and response, legal range 0..15.

Ports:
- Clk  in  1  rising-edge clock.
- Clrn  in  1  asynchronous active-low reset.
- Req  in  1  fetch request; accepted when Req=1 and Ready=1 on a rising edge.
- Addr  in  ADDR_W  byte address; sampled only on acceptance.
- Ready  out  1  unit can accept a request this cycle.
- Valid  out  1  one-cycle pulse; Inst and Fault are meaningful.
- Inst  out  DATA_W  fetched word; held until the next response.
- Fault  out  1  set with Valid when the accepted address was bad.
- WrEn  in  1  program-port write strobe.
- WrAddr  in  DEPTH_LOG2  word index to write.
- WrData  in  DATA_W  word to write.

Behaviour:
- Reset (Clrn=0, asynchronous): state=IDLE, Ready=1, Valid=0, Inst=0, Fault=0, wait counter=0. Memory array contents are not reset. Reset during WAIT aborts the fetch with no response.
- States:
  - IDLE: Ready=1.
  - WAIT: Ready=0; counter decrements each cycle.
  - RESP: Valid=1 for exactly one cycle; Ready=1.
- Acceptance (IDLE or RESP, Req=1): latch Addr and load counter=WAIT_STATES.
  - WAIT_STATES=0: go straight to RESP.
  - Otherwise go to WAIT.
- WAIT -> RESP on the edge where the counter is 1. On that same edge Inst is loaded from array[latched Addr[DEPTH_LOG2+1:2]].
- Latency: Valid asserts exactly WAIT_STATES+1 cycles after the accepting edge.
- RESP without a new Req -> IDLE. RESP with Req -> new fetch accepted, giving back-to-back throughput of one response per WAIT_STATES+1 cycles.
- Fault: the latched address has Addr[1:0]!=0, or any of Addr[ADDR_W-1:DEPTH_LOG2+2] set.
  - The response still follows the normal latency.
  - Inst=0 (NOP encoding), Fault=1.
  - No array read.
- Non-fault responses drive Fault=0.
- Write port: on the rising edge with WrEn=1, array[WrAddr]=WrData. It is accepted in any state, independent of the handshake.
- Same-edge write and read of the same word: Inst gets the old contents (read-before-write). The new word is visible to later fetches.
- Req while Ready=0 is ignored, not queued.

Optional Feature:
- Macro IMEM_FETCH_FLUSH_EN, which adds input port Flush (1 bit).
- With the macro:
  - Flush=1 in WAIT moves the FSM to IDLE on the next edge; no Valid is produced for the pending fetch.
  - Flush=1 in RESP suppresses nothing already driven, but blocks acceptance.
  - Ready = base Ready AND NOT Flush, so a Req coincident with Flush is dropped.
  - Flush in IDLE has no effect apart from Ready=0.
- Without the macro: no Flush port; every accepted fetch always completes.

Test Plan:
- Reset then idle (WAIT_STATES=1): Clrn low mid-cycle -> Ready=1, Valid=0, Inst=0, Fault=0 immediately, without waiting for a clock edge.
- Program and fetch (WAIT_STATES=1):
  - Stimulus: write array[0]=0x20010054 and array[1]=0x20020033; Req with Addr=0x0, then Addr=0x4 back-to-back.
  - Response: Valid on cycles +2 and +4 with Inst=0x20010054 then 0x20020033, Fault=0.
- Latency sweep WAIT_STATES=0 and 3: Req Addr=0x8 -> Valid exactly 1 and 4 cycles after acceptance; Ready=0 during WAIT; Req during WAIT ignored.
- Faults:
  - Req Addr=0x6 -> Valid with Fault=1, Inst=0.
  - Req Addr=0x400 (DEPTH_LOG2=8) -> Fault=1, Inst=0.
  - Next good fetch -> Fault=0.
- Read/write collision (WAIT_STATES=1): array[5]=0xAAAA0000; on the edge where the fetch of Addr=0x14 loads Inst, write WrAddr=5 with 0x5555FFFF.
  - That response returns Inst=0xAAAA0000.
  - A refetch returns 0x5555FFFF.
- Flush with IMEM_FETCH_FLUSH_EN (WAIT_STATES=3):
  - Accept Addr=0x0, pulse Flush on cycle +1 -> no Valid; FSM IDLE next cycle.
  - Req coincident with Flush is not accepted.
  - A subsequent Req completes normally.
